// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, opcode encodings and the entry record for the ALU reservation station.
package alu_reservation_station_pkg;

   localparam int IDWidth       = 32;
   localparam int ROBWidth      = 5;
   localparam int AddressWidth  = 32;
   localparam int InstTypeWidth = 6;
   localparam int RSSize        = 16;
   localparam int RSIdxW        = 4;

   localparam logic [InstTypeWidth-1:0] NOP   = 6'd0;
   localparam logic [InstTypeWidth-1:0] ADD   = 6'd1;
   localparam logic [InstTypeWidth-1:0] SUB   = 6'd2;
   localparam logic [InstTypeWidth-1:0] AND_  = 6'd3;
   localparam logic [InstTypeWidth-1:0] OR_   = 6'd4;
   localparam logic [InstTypeWidth-1:0] XOR_  = 6'd5;
   localparam logic [InstTypeWidth-1:0] BEQ   = 6'd6;
   localparam logic [InstTypeWidth-1:0] BNE   = 6'd7;
   localparam logic [InstTypeWidth-1:0] LUI   = 6'd8;
   localparam logic [InstTypeWidth-1:0] AUIPC = 6'd9;
   localparam logic [InstTypeWidth-1:0] JAL   = 6'd10;
   localparam logic [InstTypeWidth-1:0] JALR  = 6'd11;

   typedef struct packed {
      logic [InstTypeWidth-1:0] opcode;
      logic [IDWidth-1:0]       vj;
      logic [IDWidth-1:0]       vk;
      logic [ROBWidth-1:0]      qj;
      logic [ROBWidth-1:0]      qk;
      logic [IDWidth-1:0]       a;
      logic [AddressWidth-1:0]  pc;
      logic [ROBWidth-1:0]      dest;
   } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_rs_picker.sv
// Priority encoder: reports whether any bit of i_vec is set and the lowest set index.
module rs_picker #(
   parameter int N     = 16,
   parameter int IDX_W = 4
) (
   input  logic [N-1:0]     i_vec,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_reservation_station.sv
// Integer reservation station: buffers issued ops, snoops ROB/LSB broadcasts, dispatches one ready op per cycle.
// Optional macro RS_AGE_ORDER_EN selects oldest-ready dispatch instead of lowest-index-ready.
module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int RS_SIZE  = RSSize,
   parameter int RS_IDX_W = RSIdxW
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     dsp_rs_en_in,
   input  logic [InstTypeWidth-1:0] dsp_rs_opcode_in,
   input  logic [IDWidth-1:0]       dsp_rs_vj_in,
   input  logic [IDWidth-1:0]       dsp_rs_vk_in,
   input  logic [ROBWidth-1:0]      dsp_rs_qj_in,
   input  logic [ROBWidth-1:0]      dsp_rs_qk_in,
   input  logic [IDWidth-1:0]       dsp_rs_a_in,
   input  logic [AddressWidth-1:0]  dsp_rs_pc_in,
   input  logic [ROBWidth-1:0]      dsp_rs_dest_in,
   output logic                     rs_dsp_full_out,
   input  logic [ROBWidth-1:0]      rob_rs_h_in,
   input  logic [IDWidth-1:0]       rob_rs_result_in,
   input  logic [ROBWidth-1:0]      lsb_rs_h_in,
   input  logic [IDWidth-1:0]       lsb_rs_result_in,
   input  logic                     rob_rs_rst_in,
   output logic [IDWidth-1:0]       rs_alu_a_out,
   output logic [IDWidth-1:0]       rs_alu_vj_out,
   output logic [IDWidth-1:0]       rs_alu_vk_out,
   output logic [ROBWidth-1:0]      rs_alu_dest_out,
   output logic [AddressWidth-1:0]  rs_alu_pc_out,
   output logic [InstTypeWidth-1:0] rs_alu_opcode_out
);

   logic [RS_SIZE-1:0]       r_busy;
   rs_entry_t                r_ent [RS_SIZE];
   logic                     r_full;
   logic [InstTypeWidth-1:0] r_op;
   logic [IDWidth-1:0]       r_a;
   logic [IDWidth-1:0]       r_vj;
   logic [IDWidth-1:0]       r_vk;
   logic [ROBWidth-1:0]      r_dest;
   logic [AddressWidth-1:0]  r_pc;

   logic [RS_SIZE-1:0]  w_ready;
   logic [RS_SIZE-1:0]  w_pick_vec;
   logic [RS_SIZE-1:0]  w_busy_nxt;
   logic                w_free_found;
   logic                w_rdy_found;
   logic [RS_IDX_W-1:0] w_free_idx;
   logic [RS_IDX_W-1:0] w_rdy_idx;
   logic                w_issue;
   logic                w_disp;
   rs_entry_t           w_new;

   // ROB bus wins when both buses carry the same tag; returns {q, v}.
   function automatic logic [ROBWidth+IDWidth-1:0] f_snoop(
      input logic [ROBWidth-1:0] q,
      input logic [IDWidth-1:0]  v
   );
      if (q != '0 && q == rob_rs_h_in)
         return {{ROBWidth{1'b0}}, rob_rs_result_in};
      else if (q != '0 && q == lsb_rs_h_in)
         return {{ROBWidth{1'b0}}, lsb_rs_result_in};
      else
         return {q, v};
   endfunction

   always_comb begin
      w_ready = '0;
      for (int i = 0; i < RS_SIZE; i++)
         w_ready[i] = r_busy[i] && (r_ent[i].qj == '0) && (r_ent[i].qk == '0);
   end

   rs_picker #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
      .i_vec   (~r_busy),
      .o_found (w_free_found),
      .o_idx   (w_free_idx)
   );

   rs_picker #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_pick (
      .i_vec   (w_pick_vec),
      .o_found (w_rdy_found),
      .o_idx   (w_rdy_idx)
   );

   assign w_issue = rdy_in && !rob_rs_rst_in && dsp_rs_en_in && !r_full && w_free_found;
   assign w_disp  = rdy_in && !rob_rs_rst_in && w_rdy_found;

`ifdef RS_AGE_ORDER_EN
   // r_age = number of younger entries still resident, so the oldest has the largest count.
   logic [RS_IDX_W-1:0] r_age [RS_SIZE];
   logic [RS_IDX_W-1:0] w_max_age;

   always_comb begin
      w_max_age  = '0;
      w_pick_vec = '0;
      for (int i = 0; i < RS_SIZE; i++)
         if (w_ready[i] && r_age[i] > w_max_age) w_max_age = r_age[i];
      for (int i = 0; i < RS_SIZE; i++)
         w_pick_vec[i] = w_ready[i] && (r_age[i] == w_max_age);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
      end else if (rdy_in && !rob_rs_rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (w_issue && w_free_idx == RS_IDX_W'(i))
               r_age[i] <= '0;
            else if (r_busy[i])
               r_age[i] <= r_age[i] + RS_IDX_W'(w_issue)
                         - RS_IDX_W'(w_disp && (r_age[i] > r_age[w_rdy_idx]));
         end
      end
   end
`else
   assign w_pick_vec = w_ready;
`endif

   always_comb begin
      w_new        = '0;
      w_new.opcode = dsp_rs_opcode_in;
      {w_new.qj, w_new.vj} = f_snoop(dsp_rs_qj_in, dsp_rs_vj_in);
      {w_new.qk, w_new.vk} = f_snoop(dsp_rs_qk_in, dsp_rs_vk_in);
      w_new.a      = dsp_rs_a_in;
      w_new.pc     = dsp_rs_pc_in;
      w_new.dest   = dsp_rs_dest_in;
   end

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_disp)  w_busy_nxt[w_rdy_idx]  = 1'b0;
      if (w_issue) w_busy_nxt[w_free_idx] = 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_busy <= '0;
         r_full <= 1'b0;
         r_op   <= NOP;
         r_a    <= '0;
         r_vj   <= '0;
         r_vk   <= '0;
         r_dest <= '0;
         r_pc   <= '0;
      end else if (!rdy_in) begin
         r_op <= NOP;
      end else if (rob_rs_rst_in) begin
         r_busy <= '0;
         r_full <= 1'b0;
         r_op   <= NOP;
         r_dest <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_full <= &w_busy_nxt;
         if (w_rdy_found) begin
            r_op   <= r_ent[w_rdy_idx].opcode;
            r_a    <= r_ent[w_rdy_idx].a;
            r_vj   <= r_ent[w_rdy_idx].vj;
            r_vk   <= r_ent[w_rdy_idx].vk;
            r_dest <= r_ent[w_rdy_idx].dest;
            r_pc   <= r_ent[w_rdy_idx].pc;
         end else begin
            r_op   <= NOP;
            r_dest <= '0;
         end
      end
   end

   // Entry payload needs no reset: busy gates every use of it.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !rob_rs_rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (w_issue && w_free_idx == RS_IDX_W'(i)) begin
               r_ent[i] <= w_new;
            end else if (r_busy[i]) begin
               {r_ent[i].qj, r_ent[i].vj} <= f_snoop(r_ent[i].qj, r_ent[i].vj);
               {r_ent[i].qk, r_ent[i].vk} <= f_snoop(r_ent[i].qk, r_ent[i].vk);
            end
         end
      end
   end

   assign rs_dsp_full_out   = r_full;
   assign rs_alu_opcode_out = r_op;
   assign rs_alu_a_out      = r_a;
   assign rs_alu_vj_out     = r_vj;
   assign rs_alu_vk_out     = r_vk;
   assign rs_alu_dest_out   = r_dest;
   assign rs_alu_pc_out     = r_pc;

endmodule
